ifu_pcgen: RTL and testbench

PC generation and fetch-request stage of the IFU. It holds the architectural fetch PC, issues one instruction-fetch request at a time to instruction memory, and forwards responses to decode. It is the consumer of the commit stage's flush interface: on `pipe_flush_req` it acknowledges, redirects the PC to `op1 + op2`, and kills any in-flight fetch so that no wrong-path instruction reaches decode.

---
 rtl/ifu_pcgen_if.sv | 37 +++
 rtl/ifu_pcgen.sv | 84 ++++++++
 tb/tb_ifu_pcgen.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/ifu_pcgen_if.sv
// rtl/ifu_pcgen_if.sv - flush, fetch-request, fetch-response and decode handshakes of the PC generator
interface ifu_pcgen_if #(
  parameter int unsigned PC_SIZE = 32
);
  logic               pipe_flush_req;
  logic [PC_SIZE-1:0] pipe_flush_add_op1;
  logic [PC_SIZE-1:0] pipe_flush_add_op2;
  logic               pipe_flush_ack;
  logic               ifu_req_valid;
  logic               ifu_req_ready;
  logic [PC_SIZE-1:0] ifu_req_pc;
  logic               ifu_rsp_valid;
  logic               ifu_rsp_ready;
  logic [31:0]        ifu_rsp_instr;
  logic               ifu_o_valid;
  logic               ifu_o_ready;
  logic [31:0]        ifu_o_ir;
  logic [PC_SIZE-1:0] ifu_o_pc;
  logic               ifu_bpu_taken;
  logic [PC_SIZE-1:0] ifu_bpu_tgt;

  modport slave (
    input  pipe_flush_req, pipe_flush_add_op1, pipe_flush_add_op2,
    input  ifu_req_ready, ifu_rsp_valid, ifu_rsp_instr, ifu_o_ready,
    input  ifu_bpu_taken, ifu_bpu_tgt,
    output pipe_flush_ack, ifu_req_valid, ifu_req_pc, ifu_rsp_ready,
    output ifu_o_valid, ifu_o_ir, ifu_o_pc
  );

  modport master (
    output pipe_flush_req, pipe_flush_add_op1, pipe_flush_add_op2,
    output ifu_req_ready, ifu_rsp_valid, ifu_rsp_instr, ifu_o_ready,
    output ifu_bpu_taken, ifu_bpu_tgt,
    input  pipe_flush_ack, ifu_req_valid, ifu_req_pc, ifu_rsp_ready,
    input  ifu_o_valid, ifu_o_ir, ifu_o_pc
  );
endinterface

// File: rtl/ifu_pcgen.sv
// rtl/ifu_pcgen.sv - fetch PC register, single-outstanding fetch requests and flush redirect with kill
module ifu_pcgen #(
  parameter int unsigned        PC_SIZE  = 32,
  parameter logic [PC_SIZE-1:0] RESET_PC = 32'h0000_0080
) (
  input  logic         clk,
  input  logic         rst_n,
  ifu_pcgen_if.slave   bus
);
  typedef enum logic [1:0] {S_BOOT, S_REQ, S_WAIT} state_t;

  state_t             state, state_nxt;
  logic [PC_SIZE-1:0] pc_r, pc_nxt;
  logic               kill_r, kill_nxt;
  logic [PC_SIZE-1:0] flush_tgt;
  logic [PC_SIZE-1:0] pred_tgt;
  logic [PC_SIZE-1:0] seq_pc;
  logic               rsp_accept;

  assign flush_tgt = (bus.pipe_flush_add_op1 + bus.pipe_flush_add_op2) & ~PC_SIZE'(3);
  assign pred_tgt  = bus.ifu_bpu_tgt & ~PC_SIZE'(3);
  assign seq_pc    = pc_r + PC_SIZE'(4);
  // A response is always drained when it is doomed, even if decode is stalled.
  assign rsp_accept = bus.ifu_rsp_valid & (bus.ifu_o_ready | kill_r | bus.pipe_flush_req);

  assign bus.ifu_req_pc = pc_r;
  assign bus.ifu_o_pc   = pc_r;
  assign bus.ifu_o_ir   = bus.ifu_rsp_instr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= S_BOOT;
      pc_r   <= RESET_PC;
      kill_r <= 1'b0;
    end else begin
      state  <= state_nxt;
      pc_r   <= pc_nxt;
      kill_r <= kill_nxt;
    end
  end

  always_comb begin
    state_nxt          = state;
    pc_nxt             = pc_r;
    kill_nxt           = kill_r;
    bus.pipe_flush_ack = 1'b0;
    bus.ifu_req_valid  = 1'b0;
    bus.ifu_rsp_ready  = 1'b0;
    bus.ifu_o_valid    = 1'b0;
    case (state)
      S_BOOT: state_nxt = S_REQ;
      S_REQ: begin
        bus.ifu_req_valid  = ~bus.pipe_flush_req;
        bus.pipe_flush_ack = bus.pipe_flush_req;
        if (bus.pipe_flush_req) begin
          pc_nxt = flush_tgt;
        end else if (bus.ifu_req_ready) begin
          state_nxt = S_WAIT;
        end
      end
      S_WAIT: begin
        bus.pipe_flush_ack = bus.pipe_flush_req;
        bus.ifu_o_valid    = bus.ifu_rsp_valid & ~kill_r & ~bus.pipe_flush_req;
        bus.ifu_rsp_ready  = bus.ifu_o_ready | kill_r | bus.pipe_flush_req;
        if (rsp_accept) begin
          state_nxt = S_REQ;
          if (kill_r || bus.pipe_flush_req) begin
            kill_nxt = 1'b0;
            if (bus.pipe_flush_req) begin
              pc_nxt = flush_tgt;
            end
          end else begin
            pc_nxt = bus.ifu_bpu_taken ? pred_tgt : seq_pc;
          end
        end else if (bus.pipe_flush_req) begin
          // Redirect now; the stale response still owed by memory is dropped later.
          pc_nxt   = flush_tgt;
          kill_nxt = 1'b1;
        end
      end
      default: state_nxt = S_BOOT;
    endcase
  end
endmodule

// File: tb/tb_ifu_pcgen.sv
// tb/tb_ifu_pcgen.sv - scoreboard bench: memory/flush stimulus, transaction-level fetch model, decoupled monitor
module tb_ifu_pcgen;
  localparam logic [31:0] RESET_PC = 32'h0000_0080;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  ifu_pcgen_if #(.PC_SIZE(32)) bus ();
  ifu_pcgen #(.PC_SIZE(32), .RESET_PC(RESET_PC)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  int total = 0;
  int bad = 0;
  int delivered = 0;
  int mcyc = 0;
  int dcyc = 0;
  int last_req = 0;
  int idle = 0;
  int delay_cnt = 0;
  bit mem_pending = 1'b0;
  bit doomed = 1'b0;
  bit chk_period = 1'b0;
  bit dir = 1'b1;
  int p_flush = 10, p_ready = 70, p_oready = 70, max_delay = 4, dir_delay = 0;
  int force_mode = 0;
  logic [31:0] f_op1, f_op2;
  logic [31:0] mem_pc = '0;
  logic [31:0] exp_req[$];
  logic [63:0] exp_o[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    bus.pipe_flush_req = 0; bus.pipe_flush_add_op1 = 0; bus.pipe_flush_add_op2 = 0;
    bus.ifu_req_ready = 0; bus.ifu_rsp_valid = 0; bus.ifu_rsp_instr = 0;
    bus.ifu_o_ready = 0; bus.ifu_bpu_taken = 0; bus.ifu_bpu_tgt = 0;
    mem_pending = 0; doomed = 0; force_mode = 0;
    exp_req.delete(); exp_o.delete();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_req_valid", bus.ifu_req_valid, 0);
    chk("rst_flush_ack", bus.pipe_flush_ack, 0);
    chk("rst_o_valid", bus.ifu_o_valid, 0);
    chk("rst_rsp_ready", bus.ifu_rsp_ready, 0);
    chk("rst_req_pc", bus.ifu_req_pc, RESET_PC);
    chk("rst_o_pc", bus.ifu_o_pc, RESET_PC);
    #1;
    dcyc = 0;
    exp_req.push_back(RESET_PC);
    rst_n = 1'b1;
  endtask

  // One cycle of stimulus; expectations are pushed as soon as the outcome is determined.
  task automatic step();
    logic [31:0] t;
    bit fl;
    @(posedge clk);
    #1;
    dcyc++;
    if (!mem_pending) begin
      bus.ifu_rsp_valid = 0;
      delay_cnt = dir ? dir_delay : int'($urandom_range(max_delay));
    end else if (!bus.ifu_rsp_valid) begin
      if (delay_cnt == 0) begin
        bus.ifu_rsp_valid = 1;
        bus.ifu_rsp_instr = dir ? 32'h0000_0013 : $urandom;
        bus.ifu_bpu_taken = dir ? (mem_pc == 32'h88) : 1'($urandom_range(1));
        bus.ifu_bpu_tgt   = dir ? 32'h0000_0203 : $urandom;
      end else begin
        delay_cnt--;
      end
    end
    bus.ifu_req_ready = dir ? 1'b1 : ($urandom_range(99) < p_ready);
    bus.ifu_o_ready   = dir ? 1'b1 : ($urandom_range(99) < p_oready);
    bus.pipe_flush_add_op1 = $urandom;
    bus.pipe_flush_add_op2 = $urandom;
    fl = 0;
    if (dcyc >= 2) begin
      if ((force_mode == 1 && !mem_pending) ||
          (force_mode == 2 && mem_pending && !bus.ifu_rsp_valid) ||
          (force_mode == 3 && bus.ifu_rsp_valid && !doomed)) begin
        fl = 1;
        bus.pipe_flush_add_op1 = f_op1;
        bus.pipe_flush_add_op2 = f_op2;
        if (force_mode == 3) bus.ifu_o_ready = 0;
        force_mode = 0;
      end else if (!dir && $urandom_range(99) < p_flush) begin
        fl = 1;
      end
    end
    bus.pipe_flush_req = fl;
    if (fl) begin
      t = bus.pipe_flush_add_op1 + bus.pipe_flush_add_op2;
      t[1:0] = 2'b00;
      exp_req.delete();
      exp_req.push_back(t);
      exp_o.delete();
      if (mem_pending) doomed = 1;
    end else if (bus.ifu_rsp_valid && !doomed && bus.ifu_o_ready) begin
      exp_o.push_back({mem_pc, bus.ifu_rsp_instr});
      t = bus.ifu_bpu_taken ? {bus.ifu_bpu_tgt[31:2], 2'b00} : mem_pc + 32'd4;
      exp_req.push_back(t);
    end
  endtask

  task automatic run_until(input int n);
    for (int i = 0; i < 200 && delivered < n; i++) step();
    chk("progress", delivered >= n, 1);
  endtask

  task automatic forced(input int mode, input logic [31:0] a, input logic [31:0] b);
    f_op1 = a; f_op2 = b; force_mode = mode;
    for (int i = 0; i < 200 && force_mode != 0; i++) step();
    chk("forced_flush_issued", force_mode, 0);
    run_until(delivered + 1);
  endtask

  always @(negedge clk) begin
    if (!rst_n) begin
      mcyc = 0; idle = 0; last_req = 0;
    end else begin
      mcyc++;
      idle++;
      if (mcyc == 1) chk("boot_req_valid", bus.ifu_req_valid, 0);
      if (mcyc == 2) chk("first_req_valid", bus.ifu_req_valid, 1);
      chk("flush_ack", bus.pipe_flush_ack, bus.pipe_flush_req);
      if (bus.pipe_flush_req) begin
        chk("flush_blocks_req", bus.ifu_req_valid, 0);
        chk("flush_blocks_o", bus.ifu_o_valid, 0);
      end
      if (bus.ifu_req_valid) chk("one_outstanding", mem_pending, 0);
      if (bus.ifu_o_valid) chk("o_valid_only_waiting", mem_pending, 1);
      if (bus.ifu_rsp_valid && (doomed || bus.pipe_flush_req)) begin
        chk("dropped_o_valid", bus.ifu_o_valid, 0);
        chk("dropped_rsp_ready", bus.ifu_rsp_ready, 1);
      end
      if (bus.ifu_req_valid && bus.ifu_req_ready) begin
        chk("req_expected", exp_req.size() != 0, 1);
        if (exp_req.size() != 0) chk("req_pc", bus.ifu_req_pc, exp_req.pop_front());
        if (chk_period && last_req != 0) chk("fetch_period", mcyc - last_req, 2);
        last_req = mcyc;
        mem_pending = 1; mem_pc = bus.ifu_req_pc; doomed = 0; idle = 0;
      end
      if (bus.ifu_rsp_valid && bus.ifu_rsp_ready) mem_pending = 0;
      if (bus.ifu_o_valid && bus.ifu_o_ready) begin
        chk("o_expected", exp_o.size() != 0, 1);
        if (exp_o.size() != 0) chk("o_pc_ir", {bus.ifu_o_pc, bus.ifu_o_ir}, exp_o.pop_front());
        delivered++;
      end
      if (idle == 100) chk("fetch_watchdog", idle < 100, 1);
    end
  end

  initial begin
    dir = 1; dir_delay = 0; chk_period = 1;
    do_reset();
    run_until(4);
    chk_period = 0;
    forced(1, 32'h0000_1000, 32'h0000_0FFE);
    forced(1, 32'hFFFF_FFF0, 32'h0000_000C);
    run_until(delivered + 1);
    dir_delay = 4;
    forced(2, 32'h0000_0300, 32'h0000_0005);
    dir_delay = 0;
    forced(3, 32'h0000_0400, 32'h0000_0000);
    dir = 0;
    for (int i = 0; i < 3000; i++) step();
    for (int i = 0; i < 200 && !(mem_pending && !bus.ifu_rsp_valid); i++) step();
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_req_valid", bus.ifu_req_valid, 0);
    chk("midrst_flush_ack", bus.pipe_flush_ack, 0);
    chk("midrst_o_valid", bus.ifu_o_valid, 0);
    chk("midrst_rsp_ready", bus.ifu_rsp_ready, 0);
    chk("midrst_req_pc", bus.ifu_req_pc, RESET_PC);
    chk("midrst_o_pc", bus.ifu_o_pc, RESET_PC);
    do_reset();
    for (int i = 0; i < 500; i++) step();
    @(negedge clk);
    #1;
    chk("delivered_some", delivered > 50, 1);
    chk("exp_o_drained", exp_o.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
